// File: rtl/sasc_fifo_wr_arb.sv
// rtl/sasc_fifo_wr_arb.sv - round-robin burst arbiter sharing the SASC FIFO write port
module sasc_fifo_wr_arb #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] din0,
  input  logic       last0,
  output logic       ack0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] din1,
  input  logic       last1,
  output logic       ack1,
  output logic       gnt1,
  input  logic       flush,
  input  logic       fifo_full,
  output logic       fifo_we,
  output logic [7:0] fifo_din,
  output logic       fifo_clr,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, FLUSH} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t     state, state_nxt;
  logic       last_served, last_served_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [3:0] cnt_inc;
  logic       beat0, beat1;

  assign gnt0     = (state == OWN0);
  assign gnt1     = (state == OWN1);
  assign fifo_clr = (state == FLUSH);
  assign busy     = (state != IDLE);

  // A write in the reset cycle would land after the FIFO has been abandoned, so rst gates it.
  assign beat0    = rst & gnt0 & req0 & ~fifo_full;
  assign beat1    = rst & gnt1 & req1 & ~fifo_full;
  assign ack0     = beat0;
  assign ack1     = beat1;
  assign fifo_we  = beat0 | beat1;
  assign fifo_din = gnt0 ? din0 : (gnt1 ? din1 : 8'h00);
  assign cnt_inc  = {1'b0, cnt} + 4'd1;

  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    cnt_nxt         = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = 3'd0;
        if (flush)
          state_nxt = FLUSH;
        else if (req0 && req1)
          state_nxt = last_served ? OWN0 : OWN1;
        else if (req0)
          state_nxt = OWN0;
        else if (req1)
          state_nxt = OWN1;
      end
      OWN0: begin
        if (beat0)
          cnt_nxt = cnt_inc[2:0];
        if (flush) begin
          state_nxt       = FLUSH;
          last_served_nxt = 1'b0;
        end else if ((beat0 && (last0 || cnt_inc == MAX_B)) || !req0) begin
          state_nxt       = IDLE;
          last_served_nxt = 1'b0;
        end
      end
      OWN1: begin
        if (beat1)
          cnt_nxt = cnt_inc[2:0];
        if (flush) begin
          state_nxt       = FLUSH;
          last_served_nxt = 1'b1;
        end else if ((beat1 && (last1 || cnt_inc == MAX_B)) || !req1) begin
          state_nxt       = IDLE;
          last_served_nxt = 1'b1;
        end
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last_served resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      cnt         <= 3'd0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sasc_fifo_wr_arb.sv
// tb/tb_sasc_fifo_wr_arb.sv - bench for sasc_fifo_wr_arb (MAX_BURST=4 and MAX_BURST=1 builds)
module tb_sasc_fifo_wr_arb;

  logic       clk = 1'b0;
  logic       rst, req0, last0, req1, last1, flush, fifo_full;
  logic [7:0] din0, din1;

  logic       ack0_a, gnt0_a, ack1_a, gnt1_a, we_a, clr_a, busy_a;
  logic       ack0_b, gnt0_b, ack1_b, gnt1_b, we_b, clr_b, busy_b;
  logic [7:0] dout_a, dout_b;
  logic [14:0] act [2];

  int n_checks = 0;
  int n_err    = 0;

  int own    [2];
  int cnt    [2];
  int lastsv [2];
  int mb     [2] = '{4, 1};
  bit pa0, pa1;

  always #5 clk = ~clk;

  sasc_fifo_wr_arb #(.MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .last0(last0), .ack0(ack0_a), .gnt0(gnt0_a),
    .req1(req1), .din1(din1), .last1(last1), .ack1(ack1_a), .gnt1(gnt1_a),
    .flush(flush), .fifo_full(fifo_full), .fifo_we(we_a), .fifo_din(dout_a),
    .fifo_clr(clr_a), .busy(busy_a)
  );

  sasc_fifo_wr_arb #(.MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .last0(last0), .ack0(ack0_b), .gnt0(gnt0_b),
    .req1(req1), .din1(din1), .last1(last1), .ack1(ack1_b), .gnt1(gnt1_b),
    .flush(flush), .fifo_full(fifo_full), .fifo_we(we_b), .fifo_din(dout_b),
    .fifo_clr(clr_b), .busy(busy_b)
  );

  // Packed view: {gnt0, gnt1, ack0, ack1, fifo_we, fifo_din, fifo_clr, busy}
  assign act[0] = {gnt0_a, gnt1_a, ack0_a, ack1_a, we_a, dout_a, clr_a, busy_a};
  assign act[1] = {gnt0_b, gnt1_b, ack0_b, ack1_b, we_b, dout_b, clr_b, busy_b};

  function automatic logic [14:0] ev(bit g0, bit g1, bit a0, bit a1, bit we,
                                     logic [7:0] d, bit clr, bit bsy);
    return {g0, g1, a0, a1, we, d, clr, bsy};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Owner: -1 nobody, 0/1 requester, 2 clearing the FIFO.
  function automatic logic [14:0] model_out(int k);
    bit g0, g1, a0, a1;
    logic [7:0] d;
    g0 = (own[k] == 0);
    g1 = (own[k] == 1);
    a0 = rst && g0 && req0 && !fifo_full;
    a1 = rst && g1 && req1 && !fifo_full;
    d  = g0 ? din0 : (g1 ? din1 : 8'h00);
    return ev(g0, g1, a0, a1, a0 || a1, d, own[k] == 2, own[k] != -1);
  endfunction

  task automatic model_step(int k);
    int  n;
    bit  rq, ls, b;
    if (!rst) begin
      own[k] = -1; lastsv[k] = 1; cnt[k] = 0;
    end else if (own[k] == -1) begin
      cnt[k] = 0;
      if (flush)             own[k] = 2;
      else if (req0 && req1) own[k] = 1 - lastsv[k];
      else if (req0)         own[k] = 0;
      else if (req1)         own[k] = 1;
    end else if (own[k] == 2) begin
      own[k] = -1;
    end else begin
      n  = own[k];
      rq = (n == 0) ? req0 : req1;
      ls = (n == 0) ? last0 : last1;
      b  = rq && !fifo_full;
      if (b) cnt[k]++;
      if (flush || (b && (ls || cnt[k] == mb[k])) || !rq) begin
        own[k]    = flush ? 2 : -1;
        lastsv[k] = n;
      end
    end
  endtask

  task automatic sample();
    logic [14:0] e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = model_out(k);
      check(k == 0 ? "model_mb4" : "model_mb1", {17'b0, act[k]}, {17'b0, e});
      if (k == 0) begin pa0 = e[12]; pa1 = e[11]; end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
  endtask

  function automatic int ackcode(int k);
    return act[k][12] ? 0 : (act[k][11] ? 1 : 2);
  endfunction

  task automatic set_in(bit r, bit q0, logic [7:0] d0, bit l0,
                        bit q1, logic [7:0] d1, bit l1, bit fl, bit fu);
    rst = r; req0 = q0; din0 = d0; last0 = l0;
    req1 = q1; din1 = d1; last1 = l1; flush = fl; fifo_full = fu;
  endtask

  typedef struct {
    bit          rst, req0;
    logic [7:0]  din0;
    bit          last0, req1;
    logic [7:0]  din1;
    bit          last1, flush, full;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, ev(0,0,0,0,0,8'h00,0,0)};
    tbl[1]  = '{1, 1, 8'h11, 0, 0, 8'h00, 0, 0, 0, ev(0,0,0,0,0,8'h00,0,0)};
    tbl[2]  = '{1, 1, 8'h11, 0, 0, 8'h00, 0, 0, 0, ev(1,0,1,0,1,8'h11,0,1)};
    tbl[3]  = '{1, 1, 8'h22, 0, 0, 8'h00, 0, 0, 0, ev(1,0,1,0,1,8'h22,0,1)};
    tbl[4]  = '{1, 1, 8'h33, 1, 0, 8'h00, 0, 0, 0, ev(1,0,1,0,1,8'h33,0,1)};
    tbl[5]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, ev(0,0,0,0,0,8'h00,0,0)};
    tbl[6]  = '{1, 1, 8'h55, 0, 1, 8'h44, 0, 0, 0, ev(0,0,0,0,0,8'h00,0,0)};
    tbl[7]  = '{1, 1, 8'h55, 0, 1, 8'h44, 0, 0, 0, ev(0,1,0,1,1,8'h44,0,1)};
    tbl[8]  = '{1, 1, 8'h55, 0, 1, 8'h66, 1, 0, 0, ev(0,1,0,1,1,8'h66,0,1)};
    tbl[9]  = '{1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, ev(0,0,0,0,0,8'h00,0,0)};
    tbl[10] = '{1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 1, ev(1,0,0,0,0,8'h55,0,1)};
    tbl[11] = '{1, 1, 8'h55, 0, 0, 8'h00, 0, 1, 1, ev(1,0,0,0,0,8'h55,0,1)};
    tbl[12] = '{1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, ev(0,0,0,0,0,8'h00,1,1)};
    tbl[13] = '{1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, ev(0,0,0,0,0,8'h00,0,0)};
    tbl[14] = '{1, 1, 8'h55, 1, 0, 8'h00, 0, 0, 0, ev(1,0,1,0,1,8'h55,0,1)};
    tbl[15] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, ev(0,0,0,0,0,8'h00,0,0)};

    set_in(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin own[k] = -1; cnt[k] = 0; lastsv[k] = 1; end

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].rst, tbl[i].req0, tbl[i].din0, tbl[i].last0,
             tbl[i].req1, tbl[i].din1, tbl[i].last1, tbl[i].flush, tbl[i].full);
      sample();
      check($sformatf("vec%0d", i), {17'b0, act[0]}, {17'b0, tbl[i].exp});
      advance();
    end

    // Contention from reset: 4/1/4/1/4 for MAX_BURST=4, strict single-beat alternation for 1.
    set_in(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    sample(); advance();
    set_in(1, 1, 8'hA0, 0, 1, 8'hB0, 0, 0, 0);
    for (int c = 0; c < 15; c++) begin
      sample();
      check($sformatf("cont4_c%0d", c), ackcode(0),
            (c == 0 || c == 5 || c == 10) ? 2 : ((c < 5 || c > 10) ? 0 : 1));
      check($sformatf("cont1_c%0d", c), ackcode(1),
            (c % 2 == 0) ? 2 : (((c - 1) / 2) % 2));
      check("excl", {31'b0, gnt0_a & gnt1_a}, 32'd0);
      advance();
    end

    // Reset mid-burst in OWN1, then a tie must go to requester 0.
    set_in(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    sample(); advance();
    set_in(1, 0, 8'h00, 0, 1, 8'h77, 0, 0, 0);
    sample(); advance();
    sample(); check("own1_beat", {31'b0, ack1_a}, 32'd1); advance();
    rst = 1'b0;
    sample(); check("rst_no_we", {31'b0, we_a}, 32'd0); advance();
    set_in(1, 1, 8'h88, 0, 1, 8'h99, 0, 0, 0);
    sample(); check("rst_idle", {17'b0, act[0]}, 32'd0); advance();
    sample(); check("rst_tie_gnt0", {30'b0, gnt0_a, gnt1_a}, 32'd2); advance();

    // Randomized traffic; requesters hold their byte until acknowledged.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom % 100) != 0;
      flush     = ($urandom % 16) == 0;
      fifo_full = ($urandom % 4) == 0;
      if (!(req0 && !pa0)) begin
        req0 = ($urandom % 3) != 0; din0 = 8'($urandom); last0 = ($urandom % 3) == 0;
      end
      if (!(req1 && !pa1)) begin
        req1 = ($urandom % 3) != 0; din1 = 8'($urandom); last1 = ($urandom % 3) == 0;
      end
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
